// File: rtl/eth_pkt_gen.sv
// Ethernet frame body source feeding eth_tx: header, payload, zero pad, then inter-frame gap.
// Define ETH_PKT_GEN_LFSR_EN to draw payload bytes from an 8-bit LFSR instead of an incrementing count.
module eth_pkt_gen #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CYCLES  = 96
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [10:0] Payload_Len,
  input  logic [47:0] Dest_Mac,
  input  logic [47:0] Src_Mac,
  input  logic [15:0] Eth_Type,
  input  logic [7:0]  Seed,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic        Busy,
  output logic [15:0] Pkt_Cnt
);

  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [10:0]   MAXP     = 11'(MAX_PAYLOAD);
  localparam logic [10:0]   MINP     = 11'(MIN_PAYLOAD);
  localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic [111:0]  hdr;
  logic [10:0]   len;
  logic [10:0]   idx;
  logic [7:0]    pay;
  logic [GW-1:0] gap_cnt;

  logic [10:0] len_clamp;
  logic [7:0]  seed_load;
  logic [7:0]  pay_nxt;

  assign len_clamp = (Payload_Len > MAXP) ? MAXP : Payload_Len;

`ifdef ETH_PKT_GEN_LFSR_EN
  // x^8+x^6+x^5+x^4+1; all-zero is the lock-up state, so a zero seed is promoted to 1
  assign seed_load = (Seed == 8'h00) ? 8'h01 : Seed;
  assign pay_nxt   = {pay[6:0], pay[7] ^ pay[5] ^ pay[4] ^ pay[3]};
`else
  assign seed_load = Seed;
  assign pay_nxt   = pay + 8'd1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = HDR;
      HDR:     if (idx == 11'd13) state_nxt = (len == 11'd0) ? PAD : PAYLOAD;
      PAYLOAD: if (idx == len - 11'd1) state_nxt = (len < MINP) ? PAD : DONE;
      PAD:     if (idx == MINP - 11'd1) state_nxt = DONE;
      DONE:    state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx restarts at 0 for the payload and keeps running through the pad,
  // so the pad ends when idx reaches MIN_PAYLOAD-1 regardless of L
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hdr     <= '0;
      len     <= '0;
      idx     <= '0;
      pay     <= '0;
      gap_cnt <= '0;
      Pkt_Cnt <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          hdr <= {Dest_Mac, Src_Mac, Eth_Type};
          len <= len_clamp;
          pay <= seed_load;
          idx <= '0;
        end
        HDR: begin
          hdr <= hdr << 8;
          idx <= (idx == 11'd13) ? 11'd0 : idx + 11'd1;
        end
        PAYLOAD: begin
          pay <= pay_nxt;
          idx <= idx + 11'd1;
        end
        PAD:  idx <= idx + 11'd1;
        DONE: gap_cnt <= '0;
        GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
      if (state_nxt == DONE) Pkt_Cnt <= Pkt_Cnt + 16'd1;
    end
  end

  always_comb begin
    Eth_Byte = 8'h00;
    case (state)
      HDR:     Eth_Byte = hdr[111:104];
      PAYLOAD: Eth_Byte = pay;
      default: ;
    endcase
  end

  assign Eth_Byte_Valid = (state == HDR) || (state == PAYLOAD) || (state == PAD);
  assign Eth_Pkt_Rdy    = (state == DONE);
  assign Busy           = (state != IDLE);

endmodule

// File: tb/tb_eth_pkt_gen.sv
// Self-checking bench for eth_pkt_gen: table-driven frames, random frames against a frame model,
// plus hand sequences for ignored Starts and reset mid-frame.
module tb_eth_pkt_gen;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [10:0] Payload_Len = '0;
  logic [47:0] Dest_Mac = '0;
  logic [47:0] Src_Mac = '0;
  logic [15:0] Eth_Type = '0;
  logic [7:0]  Seed = '0;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Rdy;
  logic        Busy;
  logic [15:0] Pkt_Cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic [10:0] len;
    logic [7:0]  seed;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    int          total;
    logic [7:0]  b14;
    logic [7:0]  last;
  } vec_t;
  vec_t tbl[5];

  eth_pkt_gen dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Payload_Len(Payload_Len),
    .Dest_Mac(Dest_Mac), .Src_Mac(Src_Mac), .Eth_Type(Eth_Type), .Seed(Seed),
    .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Busy(Busy), .Pkt_Cnt(Pkt_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Expected frame body straight from the frame rules
  task automatic build_exp(input logic [10:0] len, input logic [7:0] seed, input logic [47:0] dst,
                           input logic [47:0] src, input logic [15:0] typ);
    int L;
    logic [7:0] v;
    exp_q.delete();
    L = (int'(len) > 1500) ? 1500 : int'(len);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(dst >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(src >> (40 - 8 * i)));
    exp_q.push_back(typ[15:8]);
    exp_q.push_back(typ[7:0]);
    v = seed;
`ifdef ETH_PKT_GEN_LFSR_EN
    if (v == 8'h00) v = 8'h01;
`endif
    for (int k = 0; k < L; k++) begin
      exp_q.push_back(v);
`ifdef ETH_PKT_GEN_LFSR_EN
      v = lfsr_step(v);
`else
      v = v + 8'd1;
`endif
    end
    for (int k = L; k < 46; k++) exp_q.push_back(8'h00);
  endtask

  // Called at a negedge while idle; returns at the negedge holding the first byte
  task automatic launch(input logic [10:0] len, input logic [7:0] seed, input logic [47:0] dst,
                        input logic [47:0] src, input logic [15:0] typ);
    Payload_Len = len; Seed = seed; Dest_Mac = dst; Src_Mac = src; Eth_Type = typ;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_latency", Eth_Byte_Valid, 1'b1);
    Payload_Len = 11'($urandom); Seed = 8'($urandom);
    Dest_Mac = {16'($urandom), $urandom}; Src_Mac = {16'($urandom), $urandom};
    Eth_Type = 16'($urandom);
  endtask

  // Full frame: collect bytes, compare, check Pkt_Cnt and gap; ends at the first idle negedge
  task automatic run_frame(input string tag, input logic [10:0] len, input logic [7:0] seed,
                           input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                           input bit poke);
    int cyc = 0;
    int g = 0;
    int bad = -1;
    bit hole = 0;
    bit idle_bad = 0;
    build_exp(len, seed, dst, src, typ);
    launch(len, seed, dst, src, typ);
    got_q.delete();
    while (!Eth_Pkt_Rdy && cyc < 2000) begin
      if (Eth_Byte_Valid) got_q.push_back(Eth_Byte);
      else begin
        hole = 1;
        if (Eth_Byte != 8'h00) idle_bad = 1;
      end
      Start = (poke && got_q.size() == 20);
      @(negedge Clk);
      cyc++;
    end
    Start = 1'b0;
    check({tag, "_rdy_seen"}, Eth_Pkt_Rdy, 1'b1);
    check({tag, "_rdy_valid_low"}, {Eth_Byte_Valid, Eth_Byte}, 9'h000);
    check({tag, "_contiguous"}, {hole, idle_bad}, 2'b00);
    check({tag, "_length"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0)
      check($sformatf("%s_byte%0d", tag, bad), got_q[bad], exp_q[bad]);
    else
      check({tag, "_data"}, bad, -1);
    exp_cnt++;
    @(negedge Clk);
    check({tag, "_pkt_cnt"}, Pkt_Cnt, 16'(exp_cnt));
    idle_bad = 0;
    while (Busy && g < 500) begin
      if (Eth_Byte_Valid || Eth_Pkt_Rdy) idle_bad = 1;
      Start = (poke && g == 10);
      g++;
      @(negedge Clk);
    end
    Start = 1'b0;
    check({tag, "_gap_len"}, g, 96);
    check({tag, "_gap_quiet"}, idle_bad, 1'b0);
  endtask

  initial begin
    tbl[0] = '{11'd64,   8'h10, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 78,   8'h10, 8'h4F};
    tbl[1] = '{11'd10,   8'hFE, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h86DD, 60,   8'hFE, 8'h00};
    tbl[2] = '{11'd0,    8'h77, 48'h1234_5678_9ABC, 48'hDEAD_BEEF_0001, 16'h0806, 60,   8'h00, 8'h00};
    tbl[3] = '{11'd2000, 8'h5A, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h88B5, 1514, 8'h5A, 8'h35};
    tbl[4] = '{11'd4,    8'h01, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h0800, 60,   8'h01, 8'h00};

    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_outputs", {Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy}, 11'h000);
    check("reset_pkt_cnt", Pkt_Cnt, 16'h0000);
    Rst = 1'b0;
    @(negedge Clk);
    check("idle_not_busy", Busy, 1'b0);

    // Consecutive frames: each Start lands in the first idle cycle after the gap
    for (int t = 0; t < 5; t++) begin
      run_frame($sformatf("tbl%0d", t), tbl[t].len, tbl[t].seed, tbl[t].dst, tbl[t].src, tbl[t].typ, 1'b0);
      check($sformatf("tbl%0d_total", t), got_q.size(), tbl[t].total);
      if (got_q.size() > 14) check($sformatf("tbl%0d_b14", t), got_q[14], tbl[t].b14);
`ifndef ETH_PKT_GEN_LFSR_EN
      if (got_q.size() > 0) check($sformatf("tbl%0d_last", t), got_q[got_q.size() - 1], tbl[t].last);
`endif
    end

    // Start pulses during PAYLOAD and during GAP must not spawn a frame
    run_frame("poke", 11'd64, 8'h33, 48'h0000_0000_00AA, 48'h0000_0000_00BB, 16'h0800, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("poke_no_second", {Busy, Eth_Byte_Valid}, 2'b00);
      @(negedge Clk);
    end
    check("poke_cnt_hold", Pkt_Cnt, 16'(exp_cnt));

    for (int r = 0; r < 6; r++) begin
      logic [10:0] rl;
      rl = (r == 5) ? 11'($urandom_range(1490, 2047)) : 11'($urandom_range(0, 200));
      run_frame($sformatf("rnd%0d", r), rl, 8'($urandom), {16'($urandom), $urandom},
                {16'($urandom), $urandom}, 16'($urandom), 1'b0);
    end

    // Reset at byte 30 of a frame
    launch(11'd100, 8'h20, 48'hCAFE_CAFE_CAFE, 48'hBEEF_BEEF_BEEF, 16'h0800);
    repeat (30) @(negedge Clk);
    check("pre_reset_valid", Eth_Byte_Valid, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_outputs", {Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy}, 11'h000);
    check("midrst_pkt_cnt", Pkt_Cnt, 16'h0000);
    Rst = 1'b0;
    exp_cnt = 0;
    run_frame("post_rst", 11'd50, 8'hC0, 48'h0101_0101_0101, 48'h0202_0202_0202, 16'h0800, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_pkt_gen.md
Name: eth_pkt_gen

Overview:
- Frame source that sits directly upstream of the eth_tx stage in the Eth_Clk domain.
- Drives the eth_tx byte inputs, Eth_Byte / Eth_Byte_Valid / Eth_Pkt_Rdy, which are currently tied to 0.
- On a Start pulse it streams one Ethernet frame body, one byte per clock: destination MAC, source MAC, EtherType, then payload, zero-padded to the 46-byte minimum.
- eth_tx buffers the bytes and adds preamble, SFD and FCS; this block never emits those.

Parameters:
- MAX_PAYLOAD, 1500, payload length clamp in bytes.
- MIN_PAYLOAD, 46, minimum payload; shorter requests are zero-padded.
- IFG_CYCLES, 96, idle clocks enforced after Eth_Pkt_Rdy before the next Start is accepted (minimum 1).

Ports:
- Clk  in  1  Eth_Clk; all logic is on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request one frame; sampled only in IDLE.
- Payload_Len  in  11  requested payload bytes; captured at accepted Start.
- Dest_Mac  in  48  destination MAC; captured at accepted Start.
- Src_Mac  in  48  source MAC; captured at accepted Start.
- Eth_Type  in  16  EtherType/length; captured at accepted Start.
- Seed  in  8  first payload byte value; captured at accepted Start.
- Eth_Byte  out  8  frame byte to eth_tx.
- Eth_Byte_Valid  out  1  Eth_Byte is valid this cycle.
- Eth_Pkt_Rdy  out  1  one-cycle pulse: the complete frame has been delivered.
- Busy  out  1  high from the cycle after an accepted Start through the end of GAP.
- Pkt_Cnt  out  16  frames completed; wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst.
- Reset values: Eth_Byte=0x00, Eth_Byte_Valid=0, Eth_Pkt_Rdy=0, Busy=0, Pkt_Cnt=0, state=IDLE, all capture registers 0.
- Reset mid-frame: on the next edge all outputs return to reset values. No Eth_Pkt_Rdy is issued and Pkt_Cnt is cleared.
- States: IDLE -> HDR -> PAYLOAD -> PAD -> DONE -> GAP -> IDLE.
- IDLE:
  - Start=1 on edge N captures all fields, enters HDR and sets Busy=1 at N+1.
  - First header byte is valid at N+1, so Start-to-first-byte latency is 1 clock.
  - Start held high longer is not re-triggered until IDLE is re-entered; it is level-sampled in IDLE only.
- HDR: 14 bytes, Eth_Byte_Valid=1 each cycle, in this order:
  - Dest_Mac[47:40] down to Dest_Mac[7:0];
  - Src_Mac[47:40] down to Src_Mac[7:0];
  - Eth_Type[15:8], then Eth_Type[7:0].
- Effective length L = min(Payload_Len, MAX_PAYLOAD).
- PAYLOAD: L bytes; byte k = (Seed + k) mod 256 (8-bit wrap). Skipped if L=0.
- PAD: max(0, MIN_PAYLOAD - L) bytes of 0x00. Skipped if L >= MIN_PAYLOAD.
- Total valid bytes = 14 + max(L, MIN_PAYLOAD): 60 minimum, 1514 maximum.
- Eth_Byte_Valid is contiguous over the whole frame, with no gaps.
- DONE: one cycle with Eth_Byte_Valid=0 and Eth_Pkt_Rdy=1. Pkt_Cnt increments on the same edge and wraps 0xFFFF -> 0x0000.
- GAP: IFG_CYCLES cycles with valid=0 and Busy=1, then IDLE with Busy=0.
- Start while Busy=1 is ignored and never queued.
- Eth_Byte holds 0x00 whenever Eth_Byte_Valid=0.
- Input fields may change after capture without affecting the frame in flight.
- Counter widths:
  - byte index is 11 bits;
  - GAP counter is sized by $clog2(IFG_CYCLES+1).

Optional Feature:
- Macro: ETH_PKT_GEN_LFSR_EN.
- Defined: PAYLOAD bytes come from an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  - LFSR is loaded with Seed at accepted Start; Seed=0x00 loads 0x01.
  - Byte 0 = the loaded value; the LFSR advances once per payload byte.
  - Pad bytes remain 0x00.
- Undefined: incrementing pattern as above; no LFSR logic is synthesised.

Test Plan:
- Reset, then Start with Dest=FF:FF:FF:FF:FF:FF, Src=02:00:00:00:00:01, Type=0x0800, Len=64, Seed=0x10 -> 78 contiguous valid bytes:
  - bytes 0-5 = 0xFF; bytes 12-13 = 08,00; byte 14 = 0x10; byte 77 = 0x4F;
  - Eth_Pkt_Rdy pulses 1 cycle after byte 77; Pkt_Cnt=1; Busy falls 96 cycles later.
- Len=10, Seed=0xFE -> payload FE,FF,00,...,07, then 36 bytes 0x00; 60 bytes total.
- Len=0 -> 14 header bytes + 46 zero bytes.
- Len=2000 -> exactly 1514 bytes.
- Start pulsed during PAYLOAD and during GAP -> no second frame, Pkt_Cnt unchanged. Start in the first IDLE cycle is accepted.
- Rst asserted at byte 30 of a frame -> next cycle valid=0, no Pkt_Rdy, Pkt_Cnt=0. A subsequent Start produces a complete correct frame.
- With ETH_PKT_GEN_LFSR_EN: Seed=0x01, Len=4 -> payload equals the golden-model LFSR sequence starting at 0x01.
